// File: rtl/iq_demod_acc.sv
// IQ demodulating accumulator: per-slice mix with the LO, sum the slices,
// integrate over the gatein window, then publish through a valid/ready result.
module iq_demod_acc #(
  parameter int NSLICE = 4,
  parameter int ACCW   = 48
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NSLICE*16-1:0]  adc16xn,
  input  logic [NSLICE*16-1:0]  locos16xn,
  input  logic [NSLICE*16-1:0]  losin16xn,
  input  logic                  gatein,
  output logic [ACCW-1:0]       accx,
  output logic [ACCW-1:0]       accy,
  output logic [23:0]           nsamp,
  output logic                  sat,
  output logic                  valid,
  input  logic                  ready,
  output logic                  overrun,
  output logic                  busy
);

  localparam int SW = 33 + $clog2(NSLICE);

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  logic [NSLICE*16-1:0]   adc_d, adc_q, cos_d, cos_q, sin_d, sin_q;
  logic                   g1_d, g1_q, g2_d, g2_q, gd_d, gd_q;
  logic signed [32:0]     px_d [NSLICE];
  logic signed [32:0]     px_q [NSLICE];
  logic signed [32:0]     py_d [NSLICE];
  logic signed [32:0]     py_q [NSLICE];
  logic signed [SW-1:0]   sx_d, sx_q, sy_d, sy_q;

  state_t                 state_d, state_q;
  logic signed [ACCW-1:0] acc_x_d, acc_x_q, acc_y_d, acc_y_q;
  logic [23:0]            n_d, n_q;
  logic                   flag_d, flag_q;
  logic [ACCW-1:0]        accx_d, accx_q, accy_d, accy_q;
  logic [23:0]            nsamp_d, nsamp_q;
  logic                   sat_d, sat_q, valid_d, valid_q, overrun_d, overrun_q;

  function automatic logic signed [ACCW-1:0] sat_add(
    input  logic signed [ACCW-1:0] a,
    input  logic signed [ACCW-1:0] b,
    output logic                   ovf
  );
    logic signed [ACCW:0] t;
    t   = (ACCW+1)'(a) + (ACCW+1)'(b);
    ovf = t[ACCW] ^ t[ACCW-1];
    if (!ovf)
      sat_add = t[ACCW-1:0];
    else if (t[ACCW])
      sat_add = {1'b1, {(ACCW-1){1'b0}}};
    else
      sat_add = {1'b0, {(ACCW-1){1'b1}}};
  endfunction

  // Pipeline next-state: input capture, per-slice mixing, slice summation.
  always_comb begin
    adc_d = adc16xn;
    cos_d = locos16xn;
    sin_d = losin16xn;
    g1_d  = gatein;
    g2_d  = g1_q;
    gd_d  = g2_q;
    for (int unsigned i = 0; i < NSLICE; i++) begin
      px_d[i] = 33'($signed(adc_q[16*i +: 16])) * 33'($signed(cos_q[16*i +: 16]));
      py_d[i] = -(33'($signed(adc_q[16*i +: 16])) * 33'($signed(sin_q[16*i +: 16])));
    end
    sx_d = '0;
    sy_d = '0;
    for (int unsigned i = 0; i < NSLICE; i++) begin
      sx_d = sx_d + SW'(px_q[i]);
      sy_d = sy_d + SW'(py_q[i]);
    end
  end

  // Pipeline registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      adc_q <= '0;
      cos_q <= '0;
      sin_q <= '0;
      g1_q  <= 1'b0;
      g2_q  <= 1'b0;
      gd_q  <= 1'b0;
      for (int unsigned i = 0; i < NSLICE; i++) begin
        px_q[i] <= '0;
        py_q[i] <= '0;
      end
      sx_q  <= '0;
      sy_q  <= '0;
    end else begin
      adc_q <= adc_d;
      cos_q <= cos_d;
      sin_q <= sin_d;
      g1_q  <= g1_d;
      g2_q  <= g2_d;
      gd_q  <= gd_d;
      for (int unsigned i = 0; i < NSLICE; i++) begin
        px_q[i] <= px_d[i];
        py_q[i] <= py_d[i];
      end
      sx_q  <= sx_d;
      sy_q  <= sy_d;
    end
  end

  // Window FSM, integration and result publish/handshake.
  always_comb begin
    logic ovx, ovy;
    ovx       = 1'b0;
    ovy       = 1'b0;
    state_d   = state_q;
    acc_x_d   = acc_x_q;
    acc_y_d   = acc_y_q;
    n_d       = n_q;
    flag_d    = flag_q;
    accx_d    = accx_q;
    accy_d    = accy_q;
    nsamp_d   = nsamp_q;
    sat_d     = sat_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;

    case (state_q)
      IDLE, DONE: begin
        if (gd_q) begin
          acc_x_d = ACCW'(sx_q);
          acc_y_d = ACCW'(sy_q);
          n_d     = 24'd1;
          flag_d  = 1'b0;
          state_d = ACC;
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      ACC: begin
        if (gd_q) begin
          acc_x_d = sat_add(acc_x_q, ACCW'(sx_q), ovx);
          acc_y_d = sat_add(acc_y_q, ACCW'(sy_q), ovy);
          flag_d  = flag_q | ovx | ovy;
          n_d     = (n_q == '1) ? n_q : n_q + 24'd1;
        end else begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (valid_q && ready) begin
      valid_d   = 1'b0;
      overrun_d = 1'b0;
    end

    // Publish reads the _q accumulator, i.e. the value from before any reload above.
    if (state_q == DONE) begin
      if (!valid_q || ready) begin
        accx_d  = acc_x_q;
        accy_d  = acc_y_q;
        nsamp_d = n_q;
        sat_d   = flag_q;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  // FSM, accumulator and result registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      acc_x_q   <= '0;
      acc_y_q   <= '0;
      n_q       <= '0;
      flag_q    <= 1'b0;
      accx_q    <= '0;
      accy_q    <= '0;
      nsamp_q   <= '0;
      sat_q     <= 1'b0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_x_q   <= acc_x_d;
      acc_y_q   <= acc_y_d;
      n_q       <= n_d;
      flag_q    <= flag_d;
      accx_q    <= accx_d;
      accy_q    <= accy_d;
      nsamp_q   <= nsamp_d;
      sat_q     <= sat_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign accx    = accx_q;
  assign accy    = accy_q;
  assign nsamp   = nsamp_q;
  assign sat     = sat_q;
  assign valid   = valid_q;
  assign overrun = overrun_q;
  assign busy    = (state_q == ACC);

endmodule

// File: tb/tb_iq_demod_acc.sv
// Directed bench for iq_demod_acc (NSLICE=4, ACCW=48).
module tb_iq_demod_acc;

  localparam int    NSLICE = 4;
  localparam int    ACCW   = 48;
  // Per-cycle sum for adc=0x4000, lo=0x7FFF over 4 slices: 4*16384*32767.
  localparam longint K = 64'sd2147418112;

  logic                 clk, reset, gatein, ready;
  logic [NSLICE*16-1:0] adc16xn, locos16xn, losin16xn;
  logic [ACCW-1:0]      accx, accy;
  logic [23:0]          nsamp;
  logic                 sat, valid, overrun, busy;

  int n_cmp = 0;
  int n_err = 0;

  logic [23:0]     cap_n[$];
  logic [ACCW-1:0] cap_x[$];

  iq_demod_acc #(.NSLICE(NSLICE), .ACCW(ACCW)) dut (
    .clk(clk), .reset(reset), .adc16xn(adc16xn), .locos16xn(locos16xn),
    .losin16xn(losin16xn), .gatein(gatein), .accx(accx), .accy(accy),
    .nsamp(nsamp), .sat(sat), .valid(valid), .ready(ready),
    .overrun(overrun), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk)
    if (!reset && valid && ready) begin
      cap_n.push_back(nsamp);
      cap_x.push_back(accx);
    end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_data(input logic [15:0] a, input logic [15:0] c, input logic [15:0] s);
    adc16xn   = {NSLICE{a}};
    locos16xn = {NSLICE{c}};
    losin16xn = {NSLICE{s}};
  endtask

  task automatic run_window(input int n);
    gatein = 1'b1;
    tick(n);
    gatein = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; gatein = 1'b0; ready = 1'b0;
    set_data(16'h0, 16'h0, 16'h0);
    tick(3);
    n_cmp++; if (accx !== '0)    begin n_err++; $display("FAIL rst_accx: got %0d want 0", accx); end
    n_cmp++; if (accy !== '0)    begin n_err++; $display("FAIL rst_accy: got %0d want 0", accy); end
    n_cmp++; if (nsamp !== '0)   begin n_err++; $display("FAIL rst_nsamp: got %0d want 0", nsamp); end
    n_cmp++; if (valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", valid); end
    n_cmp++; if (overrun !== 1'b0 || sat !== 1'b0 || busy !== 1'b0)
      begin n_err++; $display("FAIL rst_flags: got ovr=%b sat=%b busy=%b want 0 0 0", overrun, sat, busy); end
    reset = 1'b0;
    tick(2);
  endtask

  task automatic test_i_path;
    set_data(16'h4000, 16'h7FFF, 16'h0000);
    ready = 1'b0;
    run_window(10);
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL i_busy: got %b want 1", busy); end
    tick(4);
    n_cmp++; if (valid !== 1'b0) begin n_err++; $display("FAIL i_lat_early: got valid=%b want 0", valid); end
    tick(1);
    n_cmp++; if (valid !== 1'b1) begin n_err++; $display("FAIL i_lat: got valid=%b want 1", valid); end
    n_cmp++; if (accx !== 48'(10*K)) begin n_err++; $display("FAIL i_accx: got %0d want %0d", $signed(accx), 10*K); end
    n_cmp++; if (accy !== '0) begin n_err++; $display("FAIL i_accy: got %0d want 0", $signed(accy)); end
    n_cmp++; if (nsamp !== 24'd10) begin n_err++; $display("FAIL i_nsamp: got %0d want 10", nsamp); end
    n_cmp++; if (sat !== 1'b0 || overrun !== 1'b0 || busy !== 1'b0)
      begin n_err++; $display("FAIL i_flags: got sat=%b ovr=%b busy=%b want 0 0 0", sat, overrun, busy); end
    ready = 1'b1;
    tick(1);
    ready = 1'b0;
    n_cmp++; if (valid !== 1'b0) begin n_err++; $display("FAIL i_consume: got valid=%b want 0", valid); end
  endtask

  task automatic test_q_path;
    set_data(16'h4000, 16'h0000, 16'h7FFF);
    ready = 1'b0;
    run_window(10);
    tick(5);
    n_cmp++; if (valid !== 1'b1) begin n_err++; $display("FAIL q_valid: got %b want 1", valid); end
    n_cmp++; if (accx !== '0) begin n_err++; $display("FAIL q_accx: got %0d want 0", $signed(accx)); end
    n_cmp++; if (accy !== 48'(-10*K)) begin n_err++; $display("FAIL q_accy: got %0d want %0d", $signed(accy), -10*K); end
    n_cmp++; if (nsamp !== 24'd10) begin n_err++; $display("FAIL q_nsamp: got %0d want 10", nsamp); end
    ready = 1'b1;
    tick(1);
    ready = 1'b0;
  endtask

  task automatic test_overrun;
    set_data(16'h4000, 16'h7FFF, 16'h0000);
    ready = 1'b0;
    run_window(3);
    tick(8);
    run_window(5);
    tick(8);
    n_cmp++; if (valid !== 1'b1) begin n_err++; $display("FAIL ovr_valid: got %b want 1", valid); end
    n_cmp++; if (nsamp !== 24'd3) begin n_err++; $display("FAIL ovr_nsamp: got %0d want 3", nsamp); end
    n_cmp++; if (accx !== 48'(3*K)) begin n_err++; $display("FAIL ovr_accx: got %0d want %0d", $signed(accx), 3*K); end
    n_cmp++; if (overrun !== 1'b1) begin n_err++; $display("FAIL ovr_set: got %b want 1", overrun); end
    ready = 1'b1;
    tick(1);
    ready = 1'b0;
    n_cmp++; if (valid !== 1'b0) begin n_err++; $display("FAIL ovr_consume_valid: got %b want 0", valid); end
    n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL ovr_clear: got %b want 0", overrun); end
  endtask

  task automatic test_back_to_back;
    set_data(16'h4000, 16'h7FFF, 16'h0000);
    cap_n.delete();
    cap_x.delete();
    ready = 1'b1;
    run_window(4);
    tick(1);
    run_window(6);
    tick(12);
    ready = 1'b0;
    n_cmp++; if (cap_n.size() != 2) begin n_err++; $display("FAIL b2b_count: got %0d results want 2", cap_n.size()); end
    else begin
      n_cmp++; if (cap_n[0] !== 24'd4) begin n_err++; $display("FAIL b2b_n0: got %0d want 4", cap_n[0]); end
      n_cmp++; if (cap_n[1] !== 24'd6) begin n_err++; $display("FAIL b2b_n1: got %0d want 6", cap_n[1]); end
      n_cmp++; if (cap_x[0] !== 48'(4*K)) begin n_err++; $display("FAIL b2b_x0: got %0d want %0d", $signed(cap_x[0]), 4*K); end
      n_cmp++; if (cap_x[1] !== 48'(6*K)) begin n_err++; $display("FAIL b2b_x1: got %0d want %0d", $signed(cap_x[1]), 6*K); end
    end
    n_cmp++; if (overrun !== 1'b0 || valid !== 1'b0)
      begin n_err++; $display("FAIL b2b_end: got ovr=%b valid=%b want 0 0", overrun, valid); end
  endtask

  task automatic test_saturation;
    set_data(16'h8000, 16'h8000, 16'h0000);
    ready = 1'b0;
    run_window(40000);
    tick(4);
    n_cmp++; if (valid !== 1'b0) begin n_err++; $display("FAIL sat_lat_early: got valid=%b want 0", valid); end
    tick(1);
    n_cmp++; if (valid !== 1'b1) begin n_err++; $display("FAIL sat_valid: got %b want 1", valid); end
    n_cmp++; if (accx !== 48'h7FFF_FFFF_FFFF) begin n_err++; $display("FAIL sat_accx: got %h want 7fffffffffff", accx); end
    n_cmp++; if (accy !== '0) begin n_err++; $display("FAIL sat_accy: got %0d want 0", $signed(accy)); end
    n_cmp++; if (nsamp !== 24'd40000) begin n_err++; $display("FAIL sat_nsamp: got %0d want 40000", nsamp); end
    n_cmp++; if (sat !== 1'b1) begin n_err++; $display("FAIL sat_flag: got %b want 1", sat); end
  endtask

  task automatic test_reset_mid_window;
    set_data(16'h4000, 16'h7FFF, 16'h0000);
    ready = 1'b0;
    gatein = 1'b1;
    tick(5);
    reset = 1'b1;
    gatein = 1'b0;
    #2;
    n_cmp++; if (accx !== '0 || accy !== '0) begin n_err++; $display("FAIL mid_rst_acc: got x=%0d y=%0d want 0 0", accx, accy); end
    n_cmp++; if (nsamp !== '0) begin n_err++; $display("FAIL mid_rst_nsamp: got %0d want 0", nsamp); end
    n_cmp++; if (valid !== 1'b0 || sat !== 1'b0 || overrun !== 1'b0 || busy !== 1'b0)
      begin n_err++; $display("FAIL mid_rst_flags: got v=%b s=%b o=%b b=%b want 0 0 0 0", valid, sat, overrun, busy); end
    tick(2);
    reset = 1'b0;
    tick(6);
    n_cmp++; if (valid !== 1'b0) begin n_err++; $display("FAIL mid_stale: got valid=%b want 0", valid); end
    run_window(2);
    tick(5);
    n_cmp++; if (valid !== 1'b1) begin n_err++; $display("FAIL mid_valid: got %b want 1", valid); end
    n_cmp++; if (nsamp !== 24'd2) begin n_err++; $display("FAIL mid_nsamp: got %0d want 2", nsamp); end
    n_cmp++; if (accx !== 48'(2*K)) begin n_err++; $display("FAIL mid_accx: got %0d want %0d", $signed(accx), 2*K); end
    n_cmp++; if (sat !== 1'b0 || overrun !== 1'b0)
      begin n_err++; $display("FAIL mid_flags: got sat=%b ovr=%b want 0 0", sat, overrun); end
  endtask

  initial begin
    test_reset();
    test_i_path();
    test_q_path();
    test_overrun();
    test_back_to_back();
    test_saturation();
    test_reset_mid_window();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/iq_demod_acc.md
IQ_DEMOD_ACC -- requirements
Module: iq_demod_acc

Interface
REQ-001 SHALL have parameter NSLICE, default 4, giving ADC samples per clock; legal values are 2, 4, 8 and 16.
REQ-002 SHALL have parameter ACCW, default 48, giving the signed accumulator and result width.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port adc16xn, input, NSLICE*16 bits: signed ADC samples, slice i at [16i+15:16i], slice 0 earliest in time.
REQ-006 SHALL have port locos16xn, input, NSLICE*16 bits: signed LO cosine per slice, same packing as adc16xn.
REQ-007 SHALL have port losin16xn, input, NSLICE*16 bits: signed LO sine per slice, same packing as adc16xn.
REQ-008 SHALL have port gatein, input, 1 bit: integration window, time-aligned with adc16xn.
REQ-009 SHALL have port accx, output, ACCW bits: signed I result.
REQ-010 SHALL have port accy, output, ACCW bits: signed Q result.
REQ-011 SHALL have port nsamp, output, 24 bits: clock cycles integrated in the window.
REQ-012 SHALL have port sat, output, 1 bit: accx or accy saturated during the window.
REQ-013 SHALL have port valid, output, 1 bit: result registers hold an unconsumed result.
REQ-014 SHALL have port ready, input, 1 bit: consumer accepts the result.
REQ-015 SHALL have port overrun, output, 1 bit: sticky, a result was dropped.
REQ-016 SHALL have port busy, output, 1 bit: state is ACC.

Function
REQ-017 Stage 1 SHALL register adc16xn, locos16xn, losin16xn and gatein.
REQ-018 Stage 2 SHALL register per-slice full-precision signed products px_i=adc_i*cos_i and py_i=-(adc_i*sin_i), 33 bits each.
REQ-019 Stage 3 SHALL register sx=sum(px_i) and sy=sum(py_i), sign-extended to 33+log2(NSLICE) bits with no truncation.
REQ-020 gatein SHALL be delayed 3 cycles to gd so that gd aligns with sx/sy.
REQ-021 FSM states SHALL be IDLE, ACC and DONE; reset state IDLE.
REQ-022 In IDLE or DONE with gd=1: acc<=s, n<=1, per-window sat flag cleared, next state ACC.
REQ-023 In ACC with gd=1: acc<=acc+s, saturating to the signed ACCW max/min, with the sat flag set on saturation; n<=n+1, saturating at 2^24-1.
REQ-024 In ACC with gd=0: acc held, next state DONE.
REQ-025 In IDLE with gd=0: hold, no action.
REQ-026 In DONE, publish: if valid=0, or ready=1 in the same cycle, then accx/accy/nsamp/sat<=acc/n/flag and valid<=1; otherwise drop the result, set overrun, and keep the old result.
REQ-027 A DONE-cycle publish SHALL use the pre-load acc even when REQ-022 reloads acc in the same cycle.
REQ-028 valid SHALL clear on valid&ready unless a publish occurs in the same cycle, in which case valid stays 1.
REQ-029 overrun SHALL clear on the first valid&ready handshake after it was set; a simultaneous new drop keeps it set.
REQ-030 Latency from the last gated input cycle to valid=1 SHALL be 5 clocks: 3 pipeline, 1 ACC-to-DONE, 1 publish.
REQ-031 The minimum window is 1 cycle; one low gatein cycle between windows SHALL produce two separate results.
REQ-032 Result outputs SHALL be stable while valid=1 and ready=0.

Reset
REQ-033 Reset SHALL force, asynchronously: state IDLE, all pipeline registers, acc and n to 0, and accx, accy, nsamp, sat, valid, overrun and busy to 0.
REQ-034 Reset asserted mid-window SHALL discard the partial window; the first gd=1 after release SHALL start a fresh window.

Verification
REQ-035 Bench SHALL cover: NSLICE=4, every adc=0x4000, cos=0x7FFF, sin=0, gatein high 10 cycles -> valid 5 cycles after the last gated cycle; accx=21474181120, accy=0, nsamp=10, sat=0.
REQ-036 Bench SHALL cover: as REQ-035 but cos=0, sin=0x7FFF -> accx=0, accy=-21474181120.
REQ-037 Bench SHALL cover: ready=0, two windows of 3 and 5 cycles -> the first result is held with nsamp=3 and overrun=1; after ready: valid=0 and overrun=0.
REQ-038 Bench SHALL cover: windows of 4 and 6 cycles separated by one low cycle, ready=1 -> two results with nsamp 4 then 6 and no overrun.
REQ-039 Bench SHALL cover: adc=cos=-32768, sin=0, 40000-cycle window -> accx=2^47-1, sat=1, nsamp=40000.
REQ-040 Bench SHALL cover: reset pulsed at cycle 5 of a 10-cycle window -> all outputs 0 immediately; the next 2-cycle window reports nsamp=2 and no stale sum.
